// File: rtl/mem_wb_buffer.sv
// In-order writeback FIFO between the memory pipe and the shared regfile/ROB completion port.
// Optional MEM_WB_BYPASS_EN: an empty buffer forwards wb_* straight to the outputs (0-cycle latency).
module mem_wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int ROB_W  = 6,
  parameter int PREG_W = 6,
  parameter int EXCP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       wb_valid_i,
  output logic                       wb_ready_o,
  input  logic                       wb_we_i,
  input  logic [PREG_W-1:0]          wb_pdest_i,
  input  logic [31:0]                wb_wdata_i,
  input  logic [ROB_W-1:0]           wb_rob_idx_i,
  input  logic [EXCP_W-1:0]          wb_excp_i,
  input  logic                       wb_store_i,
  input  logic [31:0]                wb_paddr_i,
  input  logic [31:0]                wb_sdata_i,
  input  logic                       port_gnt_i,
  output logic                       out_req_o,
  output logic                       rf_we_o,
  output logic [PREG_W-1:0]          rf_waddr_o,
  output logic [31:0]                rf_wdata_o,
  output logic                       rob_cmp_valid_o,
  output logic [ROB_W-1:0]           rob_cmp_idx_o,
  output logic [EXCP_W-1:0]          rob_cmp_excp_o,
  output logic                       rob_cmp_store_o,
  output logic [31:0]                rob_cmp_paddr_o,
  output logic [31:0]                rob_cmp_sdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              we;
    logic [PREG_W-1:0] pdest;
    logic [31:0]       wdata;
    logic [ROB_W-1:0]  rob_idx;
    logic [EXCP_W-1:0] excp;
    logic              store;
    logic [31:0]       paddr;
    logic [31:0]       sdata;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  entry_t in_entry;
  entry_t head;
  logic   empty;
  logic   byp;
  logic   push;
  logic   pop;
  logic   fifo_push;
  logic   fifo_pop;

  always_comb begin
    in_entry.we      = wb_we_i;
    in_entry.pdest   = wb_pdest_i;
    in_entry.wdata   = wb_wdata_i;
    in_entry.rob_idx = wb_rob_idx_i;
    in_entry.excp    = wb_excp_i;
    in_entry.store   = wb_store_i;
    in_entry.paddr   = wb_paddr_i;
    in_entry.sdata   = wb_sdata_i;
  end

  assign empty      = (count_q == '0);
  // Ready ignores the grant on purpose: a full buffer never pops-through in the same cycle.
  assign wb_ready_o = (count_q != CNT_W'(DEPTH));

`ifdef MEM_WB_BYPASS_EN
  assign byp = empty & wb_valid_i & ~flush_i;
`else
  assign byp = 1'b0;
`endif

  assign out_req_o = ~empty | byp;
  assign head      = byp ? in_entry : mem_q[rd_ptr_q];
  assign push      = wb_valid_i & wb_ready_o & ~flush_i;
  assign pop       = out_req_o & port_gnt_i & ~flush_i;
  // A bypassed entry that is granted completes directly and never occupies a slot.
  assign fifo_push = push & ~(byp & port_gnt_i);
  assign fifo_pop  = pop & ~empty;

  assign rf_we_o         = pop & head.we;
  assign rob_cmp_valid_o = pop;
  assign rf_waddr_o      = out_req_o ? head.pdest   : '0;
  assign rf_wdata_o      = out_req_o ? head.wdata   : '0;
  assign rob_cmp_idx_o   = out_req_o ? head.rob_idx : '0;
  assign rob_cmp_excp_o  = out_req_o ? head.excp    : '0;
  assign rob_cmp_store_o = out_req_o ? head.store   : 1'b0;
  assign rob_cmp_paddr_o = out_req_o ? head.paddr   : '0;
  assign rob_cmp_sdata_o = out_req_o ? head.sdata   : '0;
  assign count_o         = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fifo_push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_mem_wb_buffer.sv
// Self-checking bench for mem_wb_buffer: directed spec scenarios plus random traffic
// compared against a queue-based reference model.
module tb_mem_wb_buffer;

  localparam int DEPTH  = 4;
  localparam int ROB_W  = 6;
  localparam int PREG_W = 6;
  localparam int EXCP_W = 8;
`ifdef MEM_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              flush_i;
  logic              wb_valid_i;
  logic              wb_ready_o;
  logic              wb_we_i;
  logic [PREG_W-1:0] wb_pdest_i;
  logic [31:0]       wb_wdata_i;
  logic [ROB_W-1:0]  wb_rob_idx_i;
  logic [EXCP_W-1:0] wb_excp_i;
  logic              wb_store_i;
  logic [31:0]       wb_paddr_i;
  logic [31:0]       wb_sdata_i;
  logic              port_gnt_i;
  logic              out_req_o;
  logic              rf_we_o;
  logic [PREG_W-1:0] rf_waddr_o;
  logic [31:0]       rf_wdata_o;
  logic              rob_cmp_valid_o;
  logic [ROB_W-1:0]  rob_cmp_idx_o;
  logic [EXCP_W-1:0] rob_cmp_excp_o;
  logic              rob_cmp_store_o;
  logic [31:0]       rob_cmp_paddr_o;
  logic [31:0]       rob_cmp_sdata_o;
  logic [2:0]        count_o;

  mem_wb_buffer #(.DEPTH(DEPTH), .ROB_W(ROB_W), .PREG_W(PREG_W), .EXCP_W(EXCP_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o), .wb_we_i(wb_we_i),
    .wb_pdest_i(wb_pdest_i), .wb_wdata_i(wb_wdata_i), .wb_rob_idx_i(wb_rob_idx_i),
    .wb_excp_i(wb_excp_i), .wb_store_i(wb_store_i), .wb_paddr_i(wb_paddr_i),
    .wb_sdata_i(wb_sdata_i), .port_gnt_i(port_gnt_i), .out_req_o(out_req_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .rob_cmp_valid_o(rob_cmp_valid_o), .rob_cmp_idx_o(rob_cmp_idx_o),
    .rob_cmp_excp_o(rob_cmp_excp_o), .rob_cmp_store_o(rob_cmp_store_o),
    .rob_cmp_paddr_o(rob_cmp_paddr_o), .rob_cmp_sdata_o(rob_cmp_sdata_o),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              we;
    logic [PREG_W-1:0] pdest;
    logic [31:0]       wdata;
    logic [ROB_W-1:0]  rob;
    logic [EXCP_W-1:0] excp;
    logic              store;
    logic [31:0]       paddr;
    logic [31:0]       sdata;
  } ent_t;

  // Reference model: the buffer is just an ordered list of pending writebacks.
  ent_t model_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  bit   plan_clear;
  bit   plan_pop;
  bit   plan_push;
  ent_t plan_ent;

  function automatic ent_t mk(input logic we, input int pdest, input logic [31:0] wdata,
                              input int rob, input logic store, input logic [31:0] paddr,
                              input logic [31:0] sdata);
    ent_t e;
    e.we    = we;
    e.pdest = PREG_W'(pdest);
    e.wdata = wdata;
    e.rob   = ROB_W'(rob);
    e.excp  = EXCP_W'(rob * 3);
    e.store = store;
    e.paddr = paddr;
    e.sdata = sdata;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    return mk(1'($urandom), int'($urandom_range(0, 63)), $urandom, int'($urandom_range(0, 63)),
              1'($urandom), $urandom, $urandom);
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare all outputs against the model, and plan the model update.
  task automatic applyStimulus(input string name, input bit rst_v, input bit flush_v,
                               input bit gnt_v, input bit valid_v, input ent_t e,
                               input bit chk = 1'b1);
    bit   exp_ready, exp_req, exp_pop, byp;
    ent_t head;
    rst          = rst_v;
    flush_i      = flush_v;
    port_gnt_i   = gnt_v;
    wb_valid_i   = valid_v;
    wb_we_i      = e.we;
    wb_pdest_i   = e.pdest;
    wb_wdata_i   = e.wdata;
    wb_rob_idx_i = e.rob;
    wb_excp_i    = e.excp;
    wb_store_i   = e.store;
    wb_paddr_i   = e.paddr;
    wb_sdata_i   = e.sdata;
    #1;
    exp_ready = (model_q.size() != DEPTH);
    byp       = BYP && (model_q.size() == 0) && valid_v && !flush_v;
    exp_req   = (model_q.size() != 0) || byp;
    head      = byp ? e : ((model_q.size() != 0) ? model_q[0] : '0);
    exp_pop   = exp_req && gnt_v && !flush_v;
    if (chk) begin
      checkOutput({name, ".ready"}, 128'(wb_ready_o), 128'(exp_ready));
      checkOutput({name, ".strobes"}, 128'({out_req_o, rf_we_o, rob_cmp_valid_o}),
                  128'({exp_req, exp_pop && head.we, exp_pop}));
      checkOutput({name, ".data"},
                  128'({rf_waddr_o, rf_wdata_o, rob_cmp_idx_o, rob_cmp_excp_o,
                        rob_cmp_store_o, rob_cmp_paddr_o, rob_cmp_sdata_o}),
                  exp_req ? 128'({head.pdest, head.wdata, head.rob, head.excp,
                                  head.store, head.paddr, head.sdata}) : 128'(0));
      checkOutput({name, ".count"}, 128'(count_o), 128'(model_q.size()));
    end
    plan_clear = rst_v || flush_v;
    plan_pop   = exp_pop && (model_q.size() != 0);
    plan_push  = valid_v && exp_ready && !flush_v && !(byp && gnt_v);
    plan_ent   = e;
  endtask

  task automatic tick();
    @(posedge clk);
    if (plan_clear) begin
      model_q.delete();
    end else begin
      if (plan_pop) void'(model_q.pop_front());
      if (plan_push) model_q.push_back(plan_ent);
    end
    #1;
  endtask

  initial begin
    ent_t e5;
    rst = 1'b1; flush_i = 1'b0; wb_valid_i = 1'b0; port_gnt_i = 1'b0;
    wb_we_i = 1'b0; wb_pdest_i = '0; wb_wdata_i = '0; wb_rob_idx_i = '0; wb_excp_i = '0;
    wb_store_i = 1'b0; wb_paddr_i = '0; wb_sdata_i = '0;

    applyStimulus("reset", 1, 0, 0, 0, '0, 1'b0);
    tick();
    applyStimulus("after_reset", 0, 0, 1, 0, '0);
    checkOutput("after_reset.ready_one", 128'(wb_ready_o), 128'(1));
    checkOutput("after_reset.count_zero", 128'(count_o), 128'(0));
    tick();

    applyStimulus("load_push", 0, 0, 1, 1, mk(1, 5, 32'hDEADBEEF, 3, 0, 0, 0));
    tick();
`ifndef MEM_WB_BYPASS_EN
    applyStimulus("load_drain", 0, 0, 1, 0, '0);
    checkOutput("load_drain.rf_we", 128'(rf_we_o), 128'(1));
    checkOutput("load_drain.waddr", 128'(rf_waddr_o), 128'(5));
    checkOutput("load_drain.wdata", 128'(rf_wdata_o), 128'(32'hDEADBEEF));
    checkOutput("load_drain.rob_idx", 128'(rob_cmp_idx_o), 128'(3));
    tick();
`endif
    applyStimulus("load_done", 0, 0, 1, 0, '0);
    checkOutput("load_done.count", 128'(count_o), 128'(0));
    tick();

    for (int i = 0; i < 4; i++) begin
      applyStimulus("fill", 0, 0, 0, 1, mk(1, 10 + i, $urandom, i, 0, 0, 0));
      tick();
    end
    e5 = mk(1, 20, 32'h0BAD_F00D, 4, 0, 0, 0);
    applyStimulus("full", 0, 0, 0, 1, e5);
    checkOutput("full.count", 128'(count_o), 128'(4));
    checkOutput("full.ready", 128'(wb_ready_o), 128'(0));
    tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus("drain", 0, 0, 1, (k < 2), e5);
      checkOutput("drain.rob_idx", 128'(rob_cmp_idx_o), 128'(k));
      checkOutput("drain.valid", 128'(rob_cmp_valid_o), 128'(1));
      if (k == 1) checkOutput("drain.ready_after_pop", 128'(wb_ready_o), 128'(1));
      tick();
    end
    applyStimulus("drain_idle", 0, 0, 1, 0, '0);
    tick();

    for (int i = 0; i < 10; i++) begin
      applyStimulus("stream", 0, 0, 1, 1, mk(1, i, $urandom, 30 + i, 0, 0, 0));
      if (i > 0 && !BYP) checkOutput("stream.count_one", 128'(count_o), 128'(1));
      tick();
    end
    applyStimulus("stream_idle", 0, 0, 1, 0, '0);
    tick();

    applyStimulus("store_push", 0, 0, 0, 1, mk(0, 7, 32'h0, 9, 1, 32'h1000, 32'h55));
    tick();
    applyStimulus("store_drain", 0, 0, 1, 0, '0);
    checkOutput("store.rf_we", 128'(rf_we_o), 128'(0));
    checkOutput("store.flag", 128'(rob_cmp_store_o), 128'(1));
    checkOutput("store.paddr", 128'(rob_cmp_paddr_o), 128'(32'h1000));
    checkOutput("store.sdata", 128'(rob_cmp_sdata_o), 128'(32'h55));
    tick();

    for (int i = 0; i < 3; i++) begin
      applyStimulus("pre_flush", 0, 0, 0, 1, rnd_ent());
      tick();
    end
    applyStimulus("flush", 0, 1, 1, 1, rnd_ent());
    checkOutput("flush.rf_we", 128'(rf_we_o), 128'(0));
    checkOutput("flush.cmp_valid", 128'(rob_cmp_valid_o), 128'(0));
    tick();
    applyStimulus("post_flush", 0, 0, 1, 0, '0);
    checkOutput("post_flush.count", 128'(count_o), 128'(0));
    checkOutput("post_flush.out_req", 128'(out_req_o), 128'(0));
    tick();

`ifdef MEM_WB_BYPASS_EN
    applyStimulus("bypass_gnt", 0, 0, 1, 1, mk(1, 1, 32'h1234, 7, 0, 0, 0));
    checkOutput("bypass_gnt.valid", 128'(rob_cmp_valid_o), 128'(1));
    checkOutput("bypass_gnt.idx", 128'(rob_cmp_idx_o), 128'(7));
    tick();
    applyStimulus("bypass_nognt", 0, 0, 0, 1, mk(1, 1, 32'h1234, 7, 0, 0, 0));
    tick();
    applyStimulus("bypass_stored", 0, 0, 0, 0, '0);
    checkOutput("bypass_stored.count", 128'(count_o), 128'(1));
    tick();
`endif

    for (int i = 0; i < 400; i++) begin
      applyStimulus("random", ($urandom % 60) == 0, ($urandom % 25) == 0,
                    ($urandom % 3) != 0, ($urandom % 4) != 0, rnd_ent());
      tick();
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus("pre_rst", 0, 0, 0, 1, rnd_ent());
      tick();
    end
    applyStimulus("mid_rst", 1, 0, 1, 1, rnd_ent());
    tick();
    applyStimulus("post_rst", 0, 0, 1, 0, '0);
    checkOutput("post_rst.count", 128'(count_o), 128'(0));
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
